// File: rtl/lcd_nibble_writer.sv
// Sequences 4-bit write cycles to the Spartan-3E character LCD: setup, enable pulse,
// hold and gap, one or two nibbles per request, with busy/done handshake to the CPU.
module lcd_nibble_writer #(
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned PULSE_CYCLES      = 12,
    parameter int unsigned HOLD_CYCLES       = 1,
    parameter int unsigned NIBBLE_GAP_CYCLES = 50,
    parameter int unsigned CMD_GAP_CYCLES    = 2000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic       iByteMode,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oSF_CE0,
    output logic       oBusy,
    output logic       oDone
);

    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] NGAP_LD  = CNT_W'(NIBBLE_GAP_CYCLES);
    localparam logic [CNT_W-1:0] CGAP_LD  = CNT_W'(CMD_GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       data_q, data_d;
    logic [3:0]       lo_q, lo_d;
    logic             rs_q, rs_d;
    logic             last_q, last_d;   // nibble on the bus is the final one of this transfer
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(1));

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            lo_q    <= '0;
            rs_q    <= 1'b0;
            last_q  <= 1'b0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            rs_q    <= rs_d;
            last_q  <= last_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; E is computed one cycle ahead so the pin is driven from a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        lo_d    = lo_q;
        rs_d    = rs_q;
        last_d  = last_q;
        e_d     = e_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    lo_d    = iData[3:0];
                    rs_d    = iRS;
                    data_d  = iByteMode ? iData[7:4] : iData[3:0];
                    last_d  = ~iByteMode;
                    busy_d  = 1'b1;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    e_d     = 1'b1;
                    cnt_d   = PULSE_LD;
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_last) begin
                    e_d     = 1'b0;
                    cnt_d   = HOLD_LD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    cnt_d   = last_q ? CGAP_LD : NGAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_last) begin
                    if (!last_q) begin
                        data_d  = lo_q;
                        last_d  = 1'b1;
                        cnt_d   = SETUP_LD;
                        state_d = SETUP;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                e_d     = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign oLCD_Data = data_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = rs_q;
    assign oLCD_RW   = 1'b0;
    assign oSF_CE0   = 1'b1;
    assign oBusy     = busy_q;
    assign oDone     = done_q;

endmodule

// File: doc/lcd_nibble_writer.md
# lcd_nibble_writer

Downstream of the instruction ROM and CPU execute stage: converts each `LCD` instruction's payload into a correctly timed 4-bit write cycle on the Spartan-3E character LCD (SF_D[11:8], LCD_E, LCD_RS, LCD_RW). The CPU pulses a start strobe with the register value. The block sequences setup, enable pulse, hold and inter-nibble / post-command gaps at 50 MHz. It reports busy and completion so the CPU can stall instead of relying on NOP delay loops.

## Interface
Parameters (all values ≥1 and ≤65535; the counter is 16 bits):
- SETUP_CYCLES, 2: cycles RS/data are stable before E rises (40 ns at 50 MHz).
- PULSE_CYCLES, 12: E high time (240 ns).
- HOLD_CYCLES, 1: cycles data/RS are held after E falls.
- NIBBLE_GAP_CYCLES, 50: idle time between the high and low nibble of a byte (1 µs).
- CMD_GAP_CYCLES, 2000: idle time after the final nibble before done (40 µs).

Ports:
- Clock, in, 1: system clock, 50 MHz.
- Reset, in, 1: synchronous, active-high.
- iStart, in, 1: one-cycle request; accepted only while oBusy=0.
- iByteMode, in, 1: 1 = send iData[7:4] then iData[3:0]; 0 = send iData[3:0] only.
- iRS, in, 1: LCD register select for this transfer (0 = command, 1 = data).
- iData, in, 8: payload.
- oLCD_Data, out, 4: LCD DB[7:4] (SF_D[11:8]).
- oLCD_E, out, 1: LCD enable.
- oLCD_RS, out, 1: register select.
- oLCD_RW, out, 1: constant 0 (write only).
- oSF_CE0, out, 1: constant 1 (StrataFlash disabled, bus given to the LCD).
- oBusy, out, 1: transfer in progress.
- oDone, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, SETUP, PULSE, HOLD, GAP. A 16-bit down-counter and a second-nibble flag are used.
- IDLE: when iStart=1, latch iData, iRS and iByteMode. Load oLCD_Data with iData[7:4] (byte mode) or iData[3:0] (nibble mode). Load oLCD_RS with iRS. Set oBusy=1, go to SETUP, and load the counter with SETUP_CYCLES.
- SETUP: E=0. After SETUP_CYCLES cycles, go to PULSE.
- PULSE: E=1 for exactly PULSE_CYCLES cycles, then go to HOLD.
- HOLD: E=0, data and RS unchanged. After HOLD_CYCLES cycles, go to GAP.
  - If byte mode and the first nibble was just sent, load NIBBLE_GAP_CYCLES.
  - Otherwise load CMD_GAP_CYCLES.
- GAP: E=0.
  - When the count expires after the first nibble: drive the latched low nibble and go to SETUP.
  - When the count expires after the final nibble: go to IDLE with oBusy=0 and oDone=1 for that single cycle.
- iStart while oBusy=1 is ignored; the latched payload is unaffected.
- iStart in the same cycle oDone=1 is accepted, so back-to-back transfers are legal.
- oLCD_Data and oLCD_RS keep their last values while in IDLE.
- Reset outputs: oLCD_Data=0, oLCD_E=0, oLCD_RS=0, oBusy=0, oDone=0. oLCD_RW=0 and oSF_CE0=1 at all times.
- Reset asserted mid-transfer: at the next edge the state is IDLE, E=0 and all outputs are at reset values. oDone is not pulsed and the transfer is abandoned.

## Timing
- Edge at which iStart is sampled is t0. From t0+1: oBusy=1, RS/data valid, E=0.
- E rises SETUP_CYCLES cycles after t0+1, i.e. at t0+1+S, and stays high for P cycles.
- Per nibble, the block occupies S+P+H cycles before entering GAP.
- Byte mode: oBusy is high for 2(S+P+H)+NG+CG cycles; oDone is high at t0+1+that count. Defaults: 2·15+50+2000 = 2080.
- Nibble mode: oBusy is high for S+P+H+CG cycles. Defaults: 2015.
- Data and RS never change while E=1 or during the HOLD cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle 10 cycles: oLCD_E=0, oBusy=0, oDone=0, oLCD_Data=0, oLCD_RW=0, oSF_CE0=1.
- Byte mode, iRS=1, iData=8'h48 ('H'), defaults:
  - first E pulse, 12 cycles, with Data=4'h4 and RS=1;
  - second E pulse with Data=4'h8, rising edges exactly 65 cycles apart;
  - oDone at t0+2081; oBusy high for 2080 cycles.
- Nibble mode, iRS=0, iData=8'h03: a single E pulse with Data=4'h3 and RS=0; oDone at t0+2016; no second pulse.
- iStart with 8'h41 at t0+100 during a transfer of 8'h6F: it is ignored, the nibbles sent remain 6 then F, and oDone pulses exactly once.
- Assert Reset for 1 cycle while E=1 in the first nibble: E=0 and oBusy=0 the next cycle, no oDone. A following start of 8'h6C then completes normally.
- With all parameters set to 1 and iStart held high continuously in byte mode: transfers chain back-to-back, each new transfer starting in its oDone cycle; the E-pulse count matches 2× the number of transfers.
